// File: rtl/sdram_arb_mc_pkg.sv
// sdram_arb_mc_pkg: SDRAM command encodings and arbiter state constants
package sdram_arb_mc_pkg;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_ARBIT = 4'b0010;
  localparam logic [3:0] ST_AREF  = 4'b0100;
  localparam logic [3:0] ST_CH    = 4'b1000;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sdram_arb_mc_if.sv
// sdram_arb_mc_if: owner-side and pad-side signals of the multi-channel SDRAM arbiter
interface sdram_arb_mc_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 12,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
);
  logic                     init_end;
  logic [3:0]               init_cmd;
  logic [ADDR_W-1:0]        init_addr;
  logic                     ref_req;
  logic                     ref_en;
  logic                     ref_end;
  logic [3:0]               ref_cmd;
  logic [ADDR_W-1:0]        ref_addr;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        ch_end;
  logic [4*NUM_CH-1:0]      ch_cmd;
  logic [ADDR_W*NUM_CH-1:0] ch_addr;
  logic [BA_W*NUM_CH-1:0]   ch_bank;
  logic [DQ_W*NUM_CH-1:0]   ch_wdata;
  logic [NUM_CH-1:0]        ch_dq_oe;
  logic [DQ_W-1:0]          ch_rdata;
  logic [3:0]               sd_cmd;
  logic [ADDR_W-1:0]        sd_addr;
  logic [BA_W-1:0]          sd_bank;
  logic [DQ_W-1:0]          dq_out;
  logic                     dq_oe;
  logic [DQ_W-1:0]          dq_in;
  logic                     arb_err;
  modport master (
    output init_end, init_cmd, init_addr, ref_req, ref_end, ref_cmd, ref_addr,
           ch_req, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata, ch_dq_oe, dq_in,
    input  ref_en, ch_en, ch_rdata, sd_cmd, sd_addr, sd_bank, dq_out, dq_oe, arb_err
  );
  modport slave (
    input  init_end, init_cmd, init_addr, ref_req, ref_end, ref_cmd, ref_addr,
           ch_req, ch_end, ch_cmd, ch_addr, ch_bank, ch_wdata, ch_dq_oe, dq_in,
    output ref_en, ch_en, ch_rdata, sd_cmd, sd_addr, sd_bank, dq_out, dq_oe, arb_err
  );
endinterface

// File: rtl/sdram_arb_mc_rr_arb.sv
// sdram_arb_mc_rr_arb: round-robin picker, first requester at or after ptr wins
import sdram_arb_mc_pkg::*;
module sdram_arb_mc_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int IW     = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IW-1:0]     idx,
  output logic              vld
);
  int j;
  always_comb begin
    idx = '0;
    j = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_CH;
      if (req[j]) idx = IW'(j);
    end
    vld = |req;
    gnt = vld ? (NUM_CH'(1) << idx) : '0;
  end
endmodule

// File: rtl/sdram_arb_mc.sv
// sdram_arb_mc: grants the SDRAM bus to init, refresh, or one of NUM_CH channels (round-robin)
// Optional grant watchdog: define SDRAM_ARB_TIMEOUT_EN to enable TMO_CYC abort with arb_err pulse.
import sdram_arb_mc_pkg::*;
module sdram_arb_mc #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 12,
  parameter int BA_W    = 2,
  parameter int DQ_W    = 16,
  parameter int TMO_CYC = 1024
) (
  input logic          sclk,
  input logic          reset,
  sdram_arb_mc_if.slave bus
);
  localparam int IW = idx_w(NUM_CH);
  logic [3:0]        state;
  logic              ref_en;
  logic [NUM_CH-1:0] ch_en;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     cur;
  logic [NUM_CH-1:0] rr_gnt;
  logic [IW-1:0]     rr_idx;
  logic              rr_vld;
  logic              done;
  logic              busy;
  logic              tmo_hit;
  sdram_arb_mc_rr_arb #(.NUM_CH(NUM_CH), .IW(IW)) u_rr (
    .req(bus.ch_req),
    .ptr(ptr),
    .gnt(rr_gnt),
    .idx(rr_idx),
    .vld(rr_vld)
  );
  assign busy = (state == ST_AREF) || (state == ST_CH);
  assign done = ((state == ST_AREF) && bus.ref_end) || ((state == ST_CH) && bus.ch_end[cur]);
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      ref_en <= 1'b0;
      ch_en  <= '0;
      ptr    <= '0;
      cur    <= '0;
    end else begin
      ref_en <= 1'b0;
      ch_en  <= '0;
      if (state == ST_IDLE && bus.init_end) state <= ST_ARBIT;
      else if (state == ST_ARBIT && bus.ref_req) begin
        state  <= ST_AREF;
        ref_en <= 1'b1;
      end else if (state == ST_ARBIT && rr_vld) begin
        state <= ST_CH;
        ch_en <= rr_gnt;
        cur   <= rr_idx;
        ptr   <= (rr_idx == IW'(NUM_CH - 1)) ? '0 : rr_idx + 1'b1;
      end else if (done || (busy && tmo_hit)) state <= ST_ARBIT;
    end
  end
`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] tmo_cnt;
  logic          arb_err;
  assign tmo_hit = (tmo_cnt == CW'(TMO_CYC - 1));
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      arb_err <= 1'b0;
    end else begin
      tmo_cnt <= (busy && !done && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
      arb_err <= busy && !done && tmo_hit;
    end
  end
  assign bus.arb_err = arb_err;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo_hit = 1'b0;
  assign bus.arb_err = 1'b0;
`endif
  logic is_ch;
  assign is_ch = (state == ST_CH);
  always_comb begin
    bus.sd_cmd  = (state == ST_IDLE) ? bus.init_cmd :
                  (state == ST_AREF) ? bus.ref_cmd  :
                  is_ch              ? bus.ch_cmd[4*cur +: 4] : CMD_NOP;
    bus.sd_addr = (state == ST_IDLE) ? bus.init_addr :
                  (state == ST_AREF) ? bus.ref_addr  :
                  is_ch              ? bus.ch_addr[ADDR_W*cur +: ADDR_W] : '0;
    bus.sd_bank = is_ch ? bus.ch_bank[BA_W*cur +: BA_W] : '0;
    bus.dq_oe   = is_ch && bus.ch_dq_oe[cur];
    bus.dq_out  = bus.ch_wdata[DQ_W*cur +: DQ_W];
  end
  assign bus.ch_rdata = bus.dq_in;
  assign bus.ref_en   = ref_en;
  assign bus.ch_en    = ch_en;
endmodule

// File: tb/tb_sdram_arb_mc.sv
// tb_sdram_arb_mc: directed scenarios for the multi-channel SDRAM arbiter
module tb_sdram_arb_mc;
`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  logic sclk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [3:0]  cmd_tab  [4] = '{4'b0011, 4'b0100, 4'b0101, 4'b1000};
  logic [11:0] addr_tab [4] = '{12'h100, 12'h200, 12'h300, 12'h400};
  logic [15:0] wd_tab   [4] = '{16'h1111, 16'h2222, 16'hA5A5, 16'h4444};
  logic [3:0]  gnt_seq  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  sdram_arb_mc_if #(.NUM_CH(4), .ADDR_W(12), .BA_W(2), .DQ_W(16)) bus ();
  sdram_arb_mc #(.NUM_CH(4), .ADDR_W(12), .BA_W(2), .DQ_W(16), .TMO_CYC(TMO)) dut (
    .sclk(sclk),
    .reset(reset),
    .bus(bus)
  );
  always #5 sclk = ~sclk;
  task automatic tick;
    @(posedge sclk);
    @(negedge sclk);
  endtask
  task automatic test_reset;
    n_cmp++; if (bus.ref_en !== 1'b0) begin n_err++; $display("FAIL reset_ref_en got %b want 0", bus.ref_en); end
    n_cmp++; if (bus.ch_en !== 4'b0000) begin n_err++; $display("FAIL reset_ch_en got %b want 0000", bus.ch_en); end
    n_cmp++; if (bus.arb_err !== 1'b0) begin n_err++; $display("FAIL reset_arb_err got %b want 0", bus.arb_err); end
    n_cmp++; if (bus.sd_cmd !== 4'b0010 || bus.sd_addr !== 12'h400) begin n_err++; $display("FAIL reset_mux got %b/%h want 0010/400", bus.sd_cmd, bus.sd_addr); end
    n_cmp++; if (bus.dq_oe !== 1'b0 || bus.sd_bank !== 2'd0) begin n_err++; $display("FAIL reset_dq got oe=%b bank=%0d want 0/0", bus.dq_oe, bus.sd_bank); end
  endtask
  task automatic test_init;
    reset = 1'b1;
    bus.ch_req = 4'b0001;
    for (int c = 0; c < 199; c++) begin
      tick();
      n_cmp++; if (bus.ch_en !== 4'b0000 || bus.sd_cmd !== 4'b0010) begin n_err++; $display("FAIL init_wait cyc %0d got en=%b cmd=%b want 0000/0010", c, bus.ch_en, bus.sd_cmd); end
    end
    bus.ch_req = 4'b0000;
    bus.init_end = 1'b1;
    tick();
    bus.init_end = 1'b0;
    n_cmp++; if (bus.sd_cmd !== 4'b0111 || bus.sd_addr !== 12'h000) begin n_err++; $display("FAIL init_arbit got %b/%h want 0111/000", bus.sd_cmd, bus.sd_addr); end
    tick();
    n_cmp++; if (bus.sd_cmd !== 4'b0111 || bus.ch_en !== 4'b0000) begin n_err++; $display("FAIL init_hold got %b/%b want 0111/0000", bus.sd_cmd, bus.ch_en); end
  endtask
  task automatic test_fairness;
    bus.ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int w;
      int b;
      b = 0;
      while (bus.ch_en === 4'b0000 && b < 4) begin tick(); b++; end
      w = k % 4;
      n_cmp++; if (bus.ch_en !== gnt_seq[k]) begin n_err++; $display("FAIL fair_grant%0d got %b want %b", k, bus.ch_en, gnt_seq[k]); end
      n_cmp++; if (bus.sd_cmd !== cmd_tab[w] || bus.sd_addr !== addr_tab[w]) begin n_err++; $display("FAIL fair_mux%0d got %b/%h want %b/%h", k, bus.sd_cmd, bus.sd_addr, cmd_tab[w], addr_tab[w]); end
      repeat (4) tick();
      bus.ch_end = 4'b0001 << w;
      tick();
      bus.ch_end = 4'b0000;
      n_cmp++; if (bus.sd_cmd !== 4'b0111) begin n_err++; $display("FAIL fair_end%0d got %b want 0111", k, bus.sd_cmd); end
    end
    bus.ch_req = 4'b0000;
    tick();
  endtask
  task automatic test_muxing;
    bus.ch_req = 4'b0100;
    bus.dq_in = 16'h3C3C;
    tick();
    bus.ch_req = 4'b0000;
    bus.ch_dq_oe = 4'b0100;
    #1;
    n_cmp++; if (bus.ch_en !== 4'b0100) begin n_err++; $display("FAIL mux_grant got %b want 0100", bus.ch_en); end
    n_cmp++; if (bus.dq_oe !== 1'b1 || bus.dq_out !== 16'hA5A5) begin n_err++; $display("FAIL mux_dq got %b/%h want 1/a5a5", bus.dq_oe, bus.dq_out); end
    n_cmp++; if (bus.sd_bank !== 2'd2 || bus.sd_addr !== 12'h300) begin n_err++; $display("FAIL mux_bank got %0d/%h want 2/300", bus.sd_bank, bus.sd_addr); end
    n_cmp++; if (bus.ch_rdata !== 16'h3C3C) begin n_err++; $display("FAIL mux_rdata got %h want 3c3c", bus.ch_rdata); end
    bus.ch_end = 4'b0010;
    tick();
    bus.ch_end = 4'b0000;
    n_cmp++; if (bus.sd_cmd !== 4'b0101 || bus.dq_oe !== 1'b1) begin n_err++; $display("FAIL mux_stray_end got %b/%b want 0101/1", bus.sd_cmd, bus.dq_oe); end
    bus.ch_dq_oe = 4'b1011;
    #1;
    n_cmp++; if (bus.dq_oe !== 1'b0) begin n_err++; $display("FAIL mux_oe_other got %b want 0", bus.dq_oe); end
    bus.ch_dq_oe = 4'b0100;
  endtask
  task automatic test_async_reset;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.dq_oe !== 1'b0 || bus.ch_en !== 4'b0000) begin n_err++; $display("FAIL areset_out got oe=%b en=%b want 0/0000", bus.dq_oe, bus.ch_en); end
    n_cmp++; if (bus.sd_cmd !== 4'b0010 || bus.sd_bank !== 2'd0) begin n_err++; $display("FAIL areset_idle got %b/%0d want 0010/0", bus.sd_cmd, bus.sd_bank); end
    @(negedge sclk);
    reset = 1'b1;
    bus.ch_dq_oe = 4'b0000;
    tick();
    n_cmp++; if (bus.sd_cmd !== 4'b0010) begin n_err++; $display("FAIL areset_stay_idle got %b want 0010", bus.sd_cmd); end
    bus.init_end = 1'b1;
    tick();
    bus.init_end = 1'b0;
    n_cmp++; if (bus.sd_cmd !== 4'b0111) begin n_err++; $display("FAIL areset_reinit got %b want 0111", bus.sd_cmd); end
  endtask
  task automatic test_collision;
    bus.ref_req = 1'b1;
    bus.ch_req = 4'b0011;
    tick();
    bus.ref_req = 1'b0;
    n_cmp++; if (bus.ref_en !== 1'b1 || bus.ch_en !== 4'b0000) begin n_err++; $display("FAIL coll_ref got %b/%b want 1/0000", bus.ref_en, bus.ch_en); end
    n_cmp++; if (bus.sd_cmd !== 4'b0001 || bus.sd_addr !== 12'h0AB) begin n_err++; $display("FAIL coll_ref_mux got %b/%h want 0001/0ab", bus.sd_cmd, bus.sd_addr); end
    bus.ch_end = 4'b0001;
    tick();
    bus.ch_end = 4'b0000;
    n_cmp++; if (bus.ref_en !== 1'b0 || bus.sd_cmd !== 4'b0001) begin n_err++; $display("FAIL coll_aref_hold got %b/%b want 0/0001", bus.ref_en, bus.sd_cmd); end
    bus.ref_end = 1'b1;
    tick();
    bus.ref_end = 1'b0;
    n_cmp++; if (bus.sd_cmd !== 4'b0111 || bus.ch_en !== 4'b0000) begin n_err++; $display("FAIL coll_arbit got %b/%b want 0111/0000", bus.sd_cmd, bus.ch_en); end
    tick();
    bus.ch_req = 4'b0000;
    n_cmp++; if (bus.ch_en !== 4'b0001 || bus.sd_cmd !== 4'b0011) begin n_err++; $display("FAIL coll_ch got %b/%b want 0001/0011", bus.ch_en, bus.sd_cmd); end
    bus.ref_end = 1'b1;
    tick();
    bus.ref_end = 1'b0;
    n_cmp++; if (bus.sd_cmd !== 4'b0011) begin n_err++; $display("FAIL coll_stray_ref_end got %b want 0011", bus.sd_cmd); end
    bus.ch_end = 4'b0001;
    tick();
    bus.ch_end = 4'b0000;
    n_cmp++; if (bus.sd_cmd !== 4'b0111) begin n_err++; $display("FAIL coll_done got %b want 0111", bus.sd_cmd); end
  endtask
`ifdef SDRAM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    bus.ch_req = 4'b0001;
    tick();
    bus.ch_req = 4'b0000;
    n_cmp++; if (bus.ch_en !== 4'b0001) begin n_err++; $display("FAIL tmo_grant got %b want 0001", bus.ch_en); end
    for (int c = 1; c < 16; c++) begin
      tick();
      n_cmp++; if (bus.arb_err !== 1'b0 || bus.sd_cmd !== 4'b0011) begin n_err++; $display("FAIL tmo_wait cyc %0d got %b/%b want 0/0011", c, bus.arb_err, bus.sd_cmd); end
    end
    tick();
    n_cmp++; if (bus.arb_err !== 1'b1 || bus.sd_cmd !== 4'b0111) begin n_err++; $display("FAIL tmo_hit got %b/%b want 1/0111", bus.arb_err, bus.sd_cmd); end
    tick();
    n_cmp++; if (bus.arb_err !== 1'b0) begin n_err++; $display("FAIL tmo_pulse got %b want 0", bus.arb_err); end
  endtask
`endif
  initial begin
    bus.init_end = 1'b0;
    bus.init_cmd = 4'b0010;
    bus.init_addr = 12'h400;
    bus.ref_req = 1'b0;
    bus.ref_end = 1'b0;
    bus.ref_cmd = 4'b0001;
    bus.ref_addr = 12'h0AB;
    bus.ch_req = '0;
    bus.ch_end = '0;
    bus.ch_dq_oe = '0;
    bus.dq_in = '0;
    for (int i = 0; i < 4; i++) begin
      bus.ch_cmd[4*i +: 4] = cmd_tab[i];
      bus.ch_addr[12*i +: 12] = addr_tab[i];
      bus.ch_bank[2*i +: 2] = 2'(i);
      bus.ch_wdata[16*i +: 16] = wd_tab[i];
    end
    @(negedge sclk);
    test_reset();
    test_init();
    test_fairness();
    test_muxing();
    test_async_reset();
    test_collision();
`ifdef SDRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
